pipe_skid_stage: RTL

//   Generic elastic pipeline stage register for the 5-stage core (D->E, E->M, M->W boundaries).

---
 rtl/pipe_pkg.sv | 34 +++
 rtl/pipe_slot.sv | 49 ++++
 rtl/pipe_skid_stage.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// ============================================================================
// Module : pipe_pkg
// Brief  : Shared payload layout and reset constants for the pipeline stages.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    localparam int PIPE_DATA_W = 133;

    // Payload layout, LSB first: a3 | wdata | alu | pc | instr
    localparam int A3_LSB    = 0;
    localparam int A3_W      = 5;
    localparam int WDATA_LSB = A3_LSB + A3_W;
    localparam int ALU_LSB   = WDATA_LSB + 32;
    localparam int PC_LSB    = ALU_LSB + 32;
    localparam int INSTR_LSB = PC_LSB + 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] RESET_PC  = 32'h0000_3000;

    localparam logic [PIPE_DATA_W-1:0] PIPE_RST_VAL =
        (PIPE_DATA_W'(NOP_INSTR) << INSTR_LSB) | (PIPE_DATA_W'(RESET_PC) << PC_LSB);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_state_e;

endpackage

`default_nettype wire

// File: rtl/pipe_slot.sv
// ============================================================================
// Module : pipe_slot
// Brief  : One valid+data buffer entry; cleared entries carry RST_VAL.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_slot
    import pipe_pkg::*;
#(
    parameter int                DATA_W  = PIPE_DATA_W,
    parameter logic [DATA_W-1:0] RST_VAL = DATA_W'(PIPE_RST_VAL)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    // Clearing also restores RST_VAL so a stale payload never sits behind valid=0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= RST_VAL;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_data  <= RST_VAL;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_data  <= RST_VAL;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/pipe_skid_stage.sv
// ============================================================================
// Module : pipe_skid_stage
// Brief  : Elastic valid/ready pipeline register with main + skid entries.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int                DATA_W  = PIPE_DATA_W,
    parameter logic [DATA_W-1:0] RST_VAL = DATA_W'(PIPE_RST_VAL)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    occ_state_e        r_state;
    occ_state_e        w_state_nxt;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_main_load;
    logic              w_main_clear;
    logic              w_main_sel_skid;
    logic              w_skid_load;
    logic              w_skid_clear;
    logic              w_skid_valid;
    logic [DATA_W-1:0] w_skid_data;
    logic [DATA_W-1:0] w_main_din;

    // Readiness comes only from the skid flop, never from out_ready
    assign in_ready   = ~w_skid_valid & ~Reset;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;
    assign occupancy  = {1'b0, out_valid} + {1'b0, w_skid_valid};
    assign w_main_din = w_main_sel_skid ? w_skid_data : in_data;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_main_load     = 1'b0;
        w_main_clear    = 1'b0;
        w_main_sel_skid = 1'b0;
        w_skid_load     = 1'b0;
        w_skid_clear    = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_main_load = 1'b1;
                        w_state_nxt = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_out_fire && w_in_fire) begin
                        w_main_load = 1'b1;
                    end else if (w_out_fire) begin
                        w_main_clear = 1'b1;
                        w_state_nxt  = ST_EMPTY;
                    end else if (w_in_fire) begin
                        w_skid_load = 1'b1;
                        w_state_nxt = ST_FULL;
                    end
                end
                ST_FULL: begin
                    // Skid entry is older than anything upstream, so it moves up first
                    if (w_out_fire) begin
                        w_main_load     = 1'b1;
                        w_main_sel_skid = 1'b1;
                        w_skid_clear    = 1'b1;
                        w_state_nxt     = ST_ONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    pipe_slot #(
        .DATA_W  (DATA_W),
        .RST_VAL (RST_VAL)
    ) u_main (
        .clk     (Clk),
        .rst     (Reset),
        .i_flush (flush),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_data  (w_main_din),
        .o_valid (out_valid),
        .o_data  (out_data)
    );

    pipe_slot #(
        .DATA_W  (DATA_W),
        .RST_VAL (RST_VAL)
    ) u_skid (
        .clk     (Clk),
        .rst     (Reset),
        .i_flush (flush),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_data  (in_data),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data)
    );

endmodule

`default_nettype wire
